mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (index 0..NREQ-1; 0/1 = core0 I/D, 2/3 = core1 I/D).
REQ-002 Port CLK  input  1  rising-edge clock; one clock domain.
REQ-003 Port RST  input  1  asynchronous, active-high reset.
REQ-004 Port req  input  NREQ  per-requester access request, held until served.
REQ-005 Port wen  input  NREQ  1 = write, 0 = read; valid while req set.
REQ-006 Port blk  input  NREQ  1 = two-word block transfer, 0 = single word.
REQ-007 Port addr  input  NREQ x 32  word_t byte address; word-aligned.
REQ-008 Port wdata  input  NREQ x 32  word_t write data per beat.
REQ-009 Port rwait  output  NREQ  1 = requester must hold; 0 = current beat completes this cycle.
REQ-010 Port rdata  output  32  read data, valid when owner's rwait = 0.
REQ-011 Port beat  output  1  current beat index (0/1) of the active transfer.
REQ-012 Port err  output  1  one-cycle pulse when RAM reports ERROR.
REQ-013 Ports ramREN, ramWEN  output  1 each; ramaddr, ramstore  output  32; ramload  input  32; ramstate  input  ramstate_t.

Function
REQ-014 FSM states IDLE, GRANT, BEAT0, BEAT1; reset state IDLE.
REQ-015 IDLE: if any req set, select owner by round-robin starting at pointer rr, register owner, go GRANT; else stay.
REQ-016 GRANT: one-cycle registration stage, RAM enables low; go BEAT0 (arbitration-to-RAM latency 2 cycles).
REQ-017 BEAT0/BEAT1: ramREN = ~wen[owner], ramWEN = wen[owner], ramstore = wdata[owner], ramaddr = addr[owner] + 4*beat.
REQ-018 ramaddr addition is 32-bit modulo; carry discarded (wrap at 0xFFFFFFFC -> 0x00000000).
REQ-019 BEAT0 with ramstate ACCESS: rwait[owner] = 0 that cycle; if blk[owner] go BEAT1, else go IDLE.
REQ-020 BEAT1 with ramstate ACCESS: rwait[owner] = 0; go IDLE.
REQ-021 ramstate FREE or BUSY in BEAT0/BEAT1: hold state, rwait[owner] = 1.
REQ-022 ramstate ERROR in BEAT0/BEAT1: err = 1 for one cycle, rwait[owner] = 0, go IDLE; no further beat.
REQ-023 req[owner] deasserted in GRANT/BEAT0/BEAT1: abandon transfer, RAM enables low same cycle, go IDLE.
REQ-024 On every return to IDLE from a granted transfer, rr = owner + 1 modulo NREQ.
REQ-025 rwait[i] = req[i] for every non-owner i and for all i outside BEAT0/BEAT1.
REQ-026 rdata = ramload combinationally; ramREN and ramWEN never both 1.
REQ-027 Requests arriving while busy are queued only by holding req; no internal queue.
REQ-028 Simultaneous requests in IDLE: first set bit at or after rr wins; ties impossible.

Reset
REQ-029 RST asserted: state IDLE, owner 0, rr 0, beat 0, err 0 asynchronously.
REQ-030 During reset: ramREN = ramWEN = 0, ramaddr = 0, ramstore = 0, rwait = req.
REQ-031 RST mid-transfer aborts immediately; no partial beat retried after release.

Structure
REQ-032 arb_state_t enum and NREQ default live in cpu_types_pkg alongside word_t and ramstate_t.
REQ-033 One sub-module, rr_select: combinational round-robin picker (req, rr in; owner, valid out).

Verification
REQ-034 Reset then req=0001, wen=0, blk=0, addr=0x100, ramstate ACCESS on 2nd BEAT0 cycle -> ramREN=1, ramaddr=0x100, rwait[0]=0 once, IDLE, rr=1.
REQ-035 req=1111 held, RAM always ACCESS -> grants 0,1,2,3,0 in order; each non-owner rwait=1 throughout.
REQ-036 req=0100, wen=1, blk=1, addr=0x200, wdata 0xA5A5A5A5 -> ramWEN beats at 0x200 then 0x204, rwait[2]=0 twice, beat 0 then 1.
REQ-037 blk read at addr=0xFFFFFFFC -> second beat ramaddr=0x00000000.
REQ-038 ramstate ERROR during BEAT0 of owner 1 -> err pulse 1 cycle, rwait[1]=0, IDLE, rr=2, no BEAT1.
REQ-039 RST pulsed during BEAT1 of owner 3 -> ramREN/ramWEN low same cycle, state IDLE, rr=0 after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word, RAM handshake state, arbiter FSM state.
package cpu_types_pkg;

  localparam int unsigned NREQ_DEFAULT = 4;
  localparam int unsigned WORD_W       = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BEAT0 = 2'd2,
    BEAT1 = 2'd3
  } arb_state_t;

  // Index width for n requesters; never zero so single-requester builds still elaborate.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request at or after rr, wrapping.
module rr_select
  import cpu_types_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  localparam int unsigned IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] rr,
  output logic [IDXW-1:0] owner,
  output logic            valid
);

  logic [IDXW-1:0] cand;

  // Scan requesters starting at rr; the first hit wins and later hits are ignored.
  always_comb begin
    owner = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDXW'((32'(rr) + i) % NREQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        owner = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NREQ requesters,
// supporting single-word and two-word block transfers.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     wen,
  input  logic [NREQ-1:0]     blk,
  input  word_t [NREQ-1:0]    addr,
  input  word_t [NREQ-1:0]    wdata,
  output logic [NREQ-1:0]     rwait,
  output word_t               rdata,
  output logic                beat,
  output logic                err,
  output logic                ramREN,
  output logic                ramWEN,
  output word_t               ramaddr,
  output word_t               ramstore,
  input  word_t               ramload,
  input  ramstate_t           ramstate
);

  localparam int unsigned IDXW = idx_width(NREQ);

  arb_state_t      state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] rr_q, rr_d;
  logic [IDXW-1:0] rr_next;
  logic [IDXW-1:0] pick;
  logic            pick_valid;
  logic            own_req;
  logic            in_beat;

  rr_select #(.NREQ(NREQ)) u_rr_select (
    .req   (req),
    .rr    (rr_q),
    .owner (pick),
    .valid (pick_valid)
  );

  assign own_req = req[owner_q];
  assign in_beat = (state_q == BEAT0) || (state_q == BEAT1);
  assign rr_next = (owner_q == IDXW'(NREQ - 1)) ? '0 : IDXW'(owner_q + 1'b1);
  assign rdata   = ramload;

  // State, owner and round-robin pointer registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state, pointer update and RAM/requester handshake outputs.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    rwait    = req;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    err      = 1'b0;
    beat     = (state_q == BEAT1);

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick;
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (!own_req) begin
          state_d = IDLE;
          rr_d    = rr_next;
        end else begin
          state_d = BEAT0;
        end
      end

      BEAT0, BEAT1: begin
        if (!own_req) begin
          state_d = IDLE;
          rr_d    = rr_next;
        end else begin
          case (ramstate)
            ACCESS: begin
              if ((state_q == BEAT0) && blk[owner_q]) begin
                state_d = BEAT1;
              end else begin
                state_d = IDLE;
                rr_d    = rr_next;
              end
            end
            ERROR: begin
              state_d = IDLE;
              rr_d    = rr_next;
            end
            default: ;
          endcase
        end
      end

      default: state_d = IDLE;
    endcase

    // Drive the RAM only while the owner still holds its request.
    if (in_beat) begin
      ramaddr  = addr[owner_q] + ((state_q == BEAT1) ? 32'd4 : 32'd0);
      ramstore = wdata[owner_q];
      if (own_req) begin
        ramREN = ~wen[owner_q];
        ramWEN = wen[owner_q];
        if (ramstate == ACCESS) begin
          rwait[owner_q] = 1'b0;
        end else if (ramstate == ERROR) begin
          rwait[owner_q] = 1'b0;
          err            = 1'b1;
        end
      end
    end
  end

endmodule
